// File: rtl/spi_rx_sample_streamer.sv
// Decimated I/Q capture into a FIFO, streamed out as 32-bit frames over an SPI mode-0 slave.
// The SPI slave also accepts host writes to the capture-enable and decimation registers.
module spi_rx_sample_streamer #(
    parameter int unsigned FIFO_AW     = 9,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               master_clk,
    input  logic               reset,
    input  logic [11:0]        rx_a_a,
    input  logic [11:0]        rx_a_b,
    input  logic               spi_sclk,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               capture_en
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;

    typedef enum logic {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] tx_q, tx_d;
    logic        snap_ne_q, snap_ne_d;
    logic        snap_ovf_q, snap_ovf_d;
    logic        overflow_q, overflow_d;
    logic        capture_en_q, capture_en_d;
    logic [15:0] decim_q, decim_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [23:0] samp_q, samp_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [23:0] mem_q [Depth];

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [PW-1:0] level;
    logic        empty, full;
    logic [23:0] head;
    logic [5:0]  lvl_sat;
    logic [31:0] snapshot;
    logic        commit, pop, push_req, push, drop;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Extra pointer bit distinguishes full from empty.
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == PW'(Depth));
    assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        lvl_sat = (32'(level) > 32'd63) ? 6'd63 : 6'(level);
        snapshot = {~empty, overflow_q, lvl_sat, (empty ? 24'd0 : head)};
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        snap_ne_d    = snap_ne_q;
        snap_ovf_d   = snap_ovf_q;
        overflow_d   = overflow_q;
        capture_en_d = capture_en_q;
        decim_d      = decim_q;
        dcnt_d       = dcnt_q;
        samp_d       = {rx_a_a, rx_a_b};
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        commit       = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    tx_d       = snapshot;
                    bit_cnt_d  = 6'd0;
                    rx_d       = 32'd0;
                    snap_ne_d  = ~empty;
                    snap_ovf_d = overflow_q;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d = StIdle;
                    commit  = (bit_cnt_q == 6'd32);
                end else if (sclk_rise) begin
                    rx_d = {rx_q[30:0], mosi_s};
                    if (bit_cnt_q != 6'd33) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else if (sclk_fall) begin
                    tx_d = {tx_q[30:0], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase

        if (!capture_en_q || dcnt_q == decim_q) begin
            dcnt_d = 16'd0;
        end else begin
            dcnt_d = dcnt_q + 16'd1;
        end

        // A pop in the same cycle frees the slot the push needs.
        push_req = capture_en_q && (dcnt_q == 16'd0);
        pop      = commit && snap_ne_q;
        push     = push_req && (!full || pop);
        drop     = push_req && !push;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        if (commit && rx_q[31]) begin
            capture_en_d = rx_q[30];
            decim_d      = rx_q[15:0];
            dcnt_d       = 16'd0;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (commit && snap_ovf_q) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            sclk_sync_q  <= '1;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b1;
            cs_prev_q    <= 1'b1;
            state_q      <= StIdle;
            bit_cnt_q    <= 6'd0;
            rx_q         <= 32'd0;
            tx_q         <= 32'd0;
            snap_ne_q    <= 1'b0;
            snap_ovf_q   <= 1'b0;
            overflow_q   <= 1'b0;
            capture_en_q <= 1'b0;
            decim_q      <= 16'd0;
            dcnt_q       <= 16'd0;
            samp_q       <= 24'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_s;
            cs_prev_q    <= cs_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            snap_ne_q    <= snap_ne_d;
            snap_ovf_q   <= snap_ovf_d;
            overflow_q   <= overflow_d;
            capture_en_q <= capture_en_d;
            decim_q      <= decim_d;
            dcnt_q       <= dcnt_d;
            samp_q       <= samp_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge master_clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= samp_q;
        end
    end

    assign spi_miso   = tx_q[31];
    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign capture_en = capture_en_q;

endmodule
